// File: rtl/iir_biquad_cascade_if.sv
// iir_biquad_cascade_if: sample handshake, clear and coefficient bus of the biquad cascade
interface iir_biquad_cascade_if #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 4
);
    logic                 clr;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] din;
    logic                 out_valid;
    logic signed [DW-1:0] dout;
    logic                 sat;
    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic signed [CW-1:0] cfg_data;
    modport master (
        output clr, in_valid, din, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, dout, sat
    );
    modport slave (
        input  clr, in_valid, din, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, dout, sat
    );
endinterface

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: NSEC direct-form-I biquads sharing one multiply-accumulate, one term per clock
module iir_biquad_cascade #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int FRAC = 14,
    parameter int NSEC = 2,
    parameter int AW   = $clog2(5*NSEC)
) (
    input logic clk,
    input logic rst,
    iir_biquad_cascade_if.slave bus
);
    localparam int ACCW = DW + CW + 3;
    localparam int SW   = NSEC > 1 ? $clog2(NSEC) : 1;
    localparam logic signed [ACCW-1:0] RND  = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0] YMAX = (ACCW'(1) << (DW - 1)) - ACCW'(1);
    localparam logic signed [ACCW-1:0] YMIN = -YMAX - ACCW'(1);
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
    state_t                 state;
    logic signed [CW-1:0]   coef [5*NSEC];
    logic signed [DW-1:0]   x1 [NSEC];
    logic signed [DW-1:0]   x2 [NSEC];
    logic signed [DW-1:0]   y1 [NSEC];
    logic signed [DW-1:0]   y2 [NSEC];
    logic signed [DW-1:0]   x_cur;
    logic signed [ACCW-1:0] acc;
    logic [AW-1:0]          cptr;
    logic [SW-1:0]          sec;
    logic [2:0]             term;
    logic                   sat_acc;
    logic signed [DW-1:0]   opnd;
    logic signed [DW-1:0]   ysat;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACCW-1:0] sum;
    logic signed [ACCW-1:0] shf;
    logic                   hi;
    logic                   lo;
    logic                   accept;
    assign bus.in_ready = state != MAC;
    assign accept       = bus.in_ready && bus.in_valid && !bus.clr;
    // term order b0*x0, b1*x1, b2*x2, a1*y1, a2*y2; feedback terms subtract
    always_comb begin
        opnd = term == 3'd0 ? x_cur : term == 3'd1 ? x1[sec] : term == 3'd2 ? x2[sec] :
               term == 3'd3 ? y1[sec] : y2[sec];
        prod = opnd * coef[cptr];
        sum  = term >= 3'd3 ? acc - ACCW'(prod) : acc + ACCW'(prod);
        shf  = (sum + RND) >>> FRAC;
        hi   = shf > YMAX;
        lo   = shf < YMIN;
        ysat = hi ? {1'b0, {(DW-1){1'b1}}} : lo ? {1'b1, {(DW-1){1'b0}}} : shf[DW-1:0];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            acc           <= '0;
            cptr          <= '0;
            sec           <= '0;
            term          <= '0;
            x_cur         <= '0;
            sat_acc       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.dout      <= '0;
            bus.sat       <= 1'b0;
            for (int i = 0; i < 5*NSEC; i++) coef[i] <= i % 5 == 0 ? CW'(1 << FRAC) : '0;
            for (int i = 0; i < NSEC; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            if (bus.cfg_we && bus.in_ready && int'(bus.cfg_addr) < 5*NSEC) coef[bus.cfg_addr] <= bus.cfg_data;
            if (bus.clr) begin
                state <= IDLE;
                for (int i = 0; i < NSEC; i++) begin
                    x1[i] <= '0;
                    x2[i] <= '0;
                    y1[i] <= '0;
                    y2[i] <= '0;
                end
            end else if (accept) begin
                state   <= MAC;
                x_cur   <= bus.din;
                acc     <= '0;
                cptr    <= '0;
                sec     <= '0;
                term    <= '0;
                sat_acc <= 1'b0;
            end else if (state == OUT) begin
                state <= IDLE;
            end else if (state == MAC) begin
                cptr <= cptr + 1'b1;
                if (term == 3'd4) begin
                    // section done: shift its history and feed its output to the next section
                    x1[sec] <= x_cur;
                    x2[sec] <= x1[sec];
                    y1[sec] <= ysat;
                    y2[sec] <= y1[sec];
                    x_cur   <= ysat;
                    acc     <= '0;
                    term    <= '0;
                    sat_acc <= sat_acc | hi | lo;
                    if (sec == SW'(NSEC - 1)) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                        bus.dout      <= ysat;
                        bus.sat       <= sat_acc | hi | lo;
                    end else begin
                        sec <= sec + 1'b1;
                    end
                end else begin
                    acc  <= sum;
                    term <= term + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade: directed vectors against a plain-arithmetic cascade model with literal pins
module tb_iir_biquad_cascade;
    localparam int DW = 16, CW = 16, FRAC = 14, NSEC = 2, AW = 4, LAT = 5*NSEC + 1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    iir_biquad_cascade_if #(.DW(DW), .CW(CW), .AW(AW)) bus ();
    iir_biquad_cascade #(.DW(DW), .CW(CW), .FRAC(FRAC), .NSEC(NSEC), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct {int y; logic s; int t;} exp_t;
    exp_t q[$];
    exp_t e_cmp;
    int nvec = 0, nerr = 0, cyc = 0, t_acc = 0, last_acc = 0;
    int c [5*NSEC];
    int x1 [NSEC];
    int x2 [NSEC];
    int y1 [NSEC];
    int y2 [NSEC];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask
    task automatic model_reset_coef();
        for (int i = 0; i < 5*NSEC; i++) c[i] = i % 5 == 0 ? (1 << FRAC) : 0;
    endtask
    task automatic model_clear();
        for (int k = 0; k < NSEC; k++) begin
            x1[k] = 0;
            x2[k] = 0;
            y1[k] = 0;
            y2[k] = 0;
        end
    endtask
    // y = round(sum / 2^FRAC) clamped to the sample range, section by section
    task automatic model_step(input int x, output int y, output logic s);
        longint a, v, vmax, vmin;
        vmax = (longint'(1) << (DW - 1)) - 1;
        vmin = -(longint'(1) << (DW - 1));
        s = 1'b0;
        for (int k = 0; k < NSEC; k++) begin
            a = longint'(c[5*k]) * x + longint'(c[5*k+1]) * x1[k] + longint'(c[5*k+2]) * x2[k]
                - longint'(c[5*k+3]) * y1[k] - longint'(c[5*k+4]) * y2[k];
            v = (a + (longint'(1) << (FRAC - 1))) >>> FRAC;
            if (v > vmax) begin
                v = vmax;
                s = 1'b1;
            end else if (v < vmin) begin
                v = vmin;
                s = 1'b1;
            end
            x2[k] = x1[k];
            x1[k] = x;
            y2[k] = y1[k];
            y1[k] = int'(v);
            x = int'(v);
        end
        y = x;
    endtask
    always @(negedge clk) begin
        if (rst && bus.out_valid) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_out_valid: got dout=%0d, expected no output", bus.dout);
            end else begin
                e_cmp = q.pop_front();
                check("dout", int'(bus.dout), e_cmp.y);
                check("sat", int'(bus.sat), int'(e_cmp.s));
                check("latency", cyc - e_cmp.t, LAT);
            end
        end
    end
    task automatic wcfg(input int addr, input int data);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_data = CW'(data);
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        c[addr] = data;
    endtask
    task automatic do_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        model_clear();
    endtask
    task automatic send(input int x, input logic hold, input logic abort, output int my, output logic ms);
        int n = 0;
        my = 0;
        ms = 1'b0;
        @(negedge clk);
        bus.din = DW'(x);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            t_acc = cyc - 1;
            if (!hold) bus.in_valid = 1'b0;
            if (!abort) begin
                model_step(x, my, ms);
                q.push_back('{my, ms, t_acc});
            end
        end
    endtask
    task automatic sendl(input int x, input logic hold, input int ey, input logic es);
        int my;
        logic ms;
        send(x, hold, 1'b0, my, ms);
        check("model_y", my, ey);
        check("model_sat", int'(ms), int'(es));
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL missing_out_valid: got %0d outputs pending, expected 0", q.size());
            q.delete();
        end
    endtask
    int imp_in [7]  = '{1000, 0, 0, 0, 0, 0, 0};
    int imp_exp [7] = '{1000, 500, 250, 125, 63, 32, 16};
    int svals [4]   = '{7, 7, 7, -300};
    initial begin
        int my, nov;
        logic ms;
        bus.clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.din = '0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        model_reset_coef();
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_dout", int'(bus.dout), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_sat", int'(bus.sat), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        rst = 1'b1;
        sendl(1000, 1'b0, 1000, 1'b0);
        sendl(-1234, 1'b0, -1234, 1'b0);
        drain();
        wcfg(0, 8192);
        wcfg(5, 32767);
        sendl(1000, 1'b0, 1000, 1'b0);
        drain();
        wcfg(5, 16384);
        wcfg(0, 16384);
        wcfg(3, -8192);
        do_clr();
        for (int i = 0; i < 7; i++) sendl(imp_in[i], 1'b0, imp_exp[i], 1'b0);
        drain();
        wcfg(3, 0);
        wcfg(0, 32767);
        sendl(30000, 1'b0, 32767, 1'b1);
        sendl(-30000, 1'b0, -32768, 1'b1);
        sendl(100, 1'b0, 200, 1'b0);
        drain();
        wcfg(0, 16384);
        for (int i = 0; i < 4; i++) begin
            sendl(svals[i], i < 3, svals[i], 1'b0);
            check("in_ready_busy", int'(bus.in_ready), 0);
            if (i > 0) check("accept_spacing", t_acc - last_acc, LAT);
            last_acc = t_acc;
        end
        drain();
        sendl(55, 1'b0, 55, 1'b0);
        @(negedge clk);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = '0;
        bus.cfg_data = 16'sd8192;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        drain();
        sendl(321, 1'b0, 321, 1'b0);
        drain();
        wcfg(3, -8192);
        do_clr();
        sendl(1000, 1'b0, 1000, 1'b0);
        drain();
        send(777, 1'b0, 1'b1, my, ms);
        repeat (4) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        model_clear();
        nov = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) nov++;
        end
        check("abort_no_out_valid", nov, 0);
        @(negedge clk);
        bus.din = 16'sd5;
        bus.in_valid = 1'b1;
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_priority_ready", int'(bus.in_ready), 1);
        bus.in_valid = 1'b0;
        bus.clr = 1'b0;
        model_clear();
        sendl(400, 1'b0, 400, 1'b0);
        drain();
        wcfg(5, 8192);
        send(900, 1'b0, 1'b1, my, ms);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_rst_dout", int'(bus.dout), 0);
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        check("async_rst_sat", int'(bus.sat), 0);
        check("async_rst_in_ready", int'(bus.in_ready), 1);
        model_reset_coef();
        model_clear();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sendl(1234, 1'b0, 1234, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/iir_biquad_cascade.md
# iir_biquad_cascade

Parametrised cascade of NSEC second-order IIR sections (direct form I) for the audio path, with a valid/ready sample handshake and a runtime-writable coefficient bank. All sections share one time-multiplexed multiply-accumulate unit. Each section output is rounded and saturated. The block sits between the audio sample source and the output formatter and serves as the general replacement for fixed two-section filters with hard-coded coefficients.

## Interface
- DW, 16: sample width (signed) for din, dout and all section histories
- CW, 16: coefficient width (signed)
- FRAC, 14: coefficient fractional bits; 1.0 = 1<<FRAC
- NSEC, 2: number of cascaded sections, 1..8
- AW, $clog2(5*NSEC): coefficient address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all section histories and abort of any sample in flight
- in_valid  in  1  din valid
- in_ready  out  1  block can accept a sample
- din  in  DW  signed input sample
- out_valid  out  1  one-cycle pulse: dout and sat valid
- dout  out  DW  signed filtered sample, held until next out_valid
- sat  out  1  any section saturated on this sample; valid with out_valid
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  AW  address = 5*k + {0:b0, 1:b1, 2:b2, 3:a1, 4:a2} for section k
- cfg_data  in  CW  signed coefficient

## Operation
- Section k computes y = (b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2 + 2^(FRAC−1)) >>> FRAC, then saturates to [−2^(DW−1), 2^(DW−1)−1].
- The x0 of section 0 is din. The x0 of section k>0 is the saturated y of section k−1.
- Accumulator width is DW+CW+3, so no internal overflow is possible.
- Each section keeps its own x1, x2, y1, y2. These histories update only when the section completes.
- FSM states:
  - IDLE: in_ready=1. Accepting a sample moves to MAC.
  - MAC: 5 terms per section, NSEC sections, one term per clock. After the last term moves to OUT.
  - OUT: drive out_valid, then go to IDLE.
- A new sample is never lost or duplicated. There is no change-detection gating: repeated identical samples are each processed.
- Coefficient writes:
  - Accepted only while in_ready=1. cfg_we at any other time is ignored.
  - Addresses ≥ 5*NSEC are ignored.
  - A write and an accepted sample in the same cycle: the new coefficient applies to that sample.
- sat is the OR of every section's saturation event for the current sample.
- clr:
  - Zeroes all histories and forces IDLE.
  - A sample in flight produces no out_valid.
  - clr has priority over in_valid in the same cycle; the sample is not accepted.
  - Coefficients are kept.
- Reset state:
  - Histories 0, state IDLE.
  - dout=0, out_valid=0, sat=0, in_ready=1.
  - Coefficients: b0=1<<FRAC, all others 0, so every section is a pass-through.

## Timing
- Accept at cycle 0 (in_valid & in_ready at the rising edge). in_ready=0 from cycle 1.
- MAC occupies cycles 1..5*NSEC. Section k history is written at the end of cycle 5*(k+1).
- out_valid=1 in cycle 5*NSEC+1. dout and sat are registered and stable from that cycle.
- in_ready returns to 1 in the same cycle as out_valid. A sample presented then is accepted.
- Throughput is one sample per 5*NSEC+1 cycles; latency is 5*NSEC+1 cycles. For NSEC=2 both are 11.
- Asynchronous rst mid-MAC: all outputs go immediately to their reset values; no out_valid follows.

## Test plan
All scenarios use NSEC=2, DW=CW=16, FRAC=14.
- Reset pass-through: after reset, din=1000 → dout=1000, sat=0, out_valid exactly 11 cycles after accept. din=−1234 → −1234.
- Gain and cascade: write b0 of section 0 = 8192 (0.5) and b0 of section 1 = 32767 (≈2.0). din=1000 → 500 after section 0, then dout=1000 (rounded).
- Recursion and rounding: section 0 b0=16384, a1=−8192 (y=x+0.5·y1). Input impulse 1000 then zeros → dout 1000, 500, 250, 125, 63, 32, 16.
- Saturation: section 0 b0=32767. din=30000 → dout=32767, sat=1. din=−30000 → dout=−32768, sat=1. Next din=100 → dout≈200, sat=0.
- Handshake: in_valid held high continuously → exactly one accept per 11 cycles and out_valid every 11 cycles. cfg_we asserted while in_ready=0 leaves the coefficient unchanged (confirm with a pass-through sample afterwards).
- Abort: assert clr in cycle 4 of MAC → no out_valid; next sample sees zero history (recursive config gives dout=din). Repeat the scenario with rst low mid-MAC → outputs at reset values and coefficients back to pass-through.
